eth_rx_fifo_reader: RTL and testbench

//  Read-side consumer of the dual-clock Ethernet RX FIFO, running in FWFT mode. Pops packed frame words, rebuilds
//  AXI-Stream beats with tkeep/tlast, checks frame length, and flags runt, oversize and errored frames on tuser.

---
 rtl/eth_rx_pkg.sv | 45 ++++
 rtl/eth_rx_fifo_reader_skid.sv | 81 ++++++++
 rtl/eth_rx_fifo_reader.sv | 206 ++++++++++++++++++++
 tb/tb_eth_rx_fifo_reader.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eth_rx_pkg
//  Description : Shared types and constants for the Ethernet RX FIFO reader.
//                Holds the read-side FSM encoding, the packed FIFO word layout
//                at the default width, and the width helpers used by the
//                parameterised top level.
//  Revision    : 1.0  initial release
// ============================================================================
package eth_rx_pkg;

    // Default datapath and frame-length limits (classic Ethernet with VLAN tag)
    localparam int DEF_DATA_BYTES      = 4;
    localparam int DEF_MIN_FRAME_BYTES = 60;
    localparam int DEF_MAX_FRAME_BYTES = 1522;
    localparam int DEF_BCNT_W          = $clog2(DEF_DATA_BYTES);

    // Read-side frame tracking state
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FRAME   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    // Packed FIFO head word at the default width; MSB first, byte 0 in data[7:0]
    typedef struct packed {
        logic                          err;
        logic                          last;
        logic [DEF_BCNT_W-1:0]         nbytes_m1;
        logic [8*DEF_DATA_BYTES-1:0]   data;
    } rx_fifo_word_t;

    // Width of one FIFO word: data, byte count of the last word, last and err flags
    function automatic int fifo_w(input int data_bytes);
        return 8 * data_bytes + $clog2(data_bytes) + 2;
    endfunction

    // Width of the running frame length; the largest value ever formed is one
    // full word beyond the maximum frame length, so no overflow is possible
    function automatic int len_w(input int max_bytes, input int data_bytes);
        return $clog2(max_bytes + data_bytes + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/eth_rx_fifo_reader_skid.sv
`default_nettype none
// ============================================================================
//  Module      : axis_skid_buffer
//  Description : Two-entry AXI-Stream register slice. Both the output valid
//                and the upstream ready are registered, so the slice breaks
//                the combinational path in both directions while sustaining
//                one transfer per cycle. The second entry absorbs the beat
//                that arrives in the cycle the downstream stalls.
//  Revision    : 1.0  initial release
// ============================================================================
module axis_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
);

    logic [WIDTH-1:0] r_m_data;
    logic             r_m_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_skid_valid;
    logic             r_s_ready;
    logic             w_s_fire;
    logic             w_out_free;

    // Handshake qualifiers for the upstream side and the output register
    always_comb begin
        w_s_fire   = s_valid && r_s_ready;
        w_out_free = !r_m_valid || m_ready;
    end

    // Output register plus skid entry; ready is held low from reset until
    // the first clock after reset release so nothing is accepted in reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_data     <= '0;
            r_m_valid    <= 1'b0;
            r_skid_data  <= '0;
            r_skid_valid <= 1'b0;
            r_s_ready    <= 1'b0;
        end else begin
            r_s_ready <= 1'b1;
            if (!r_skid_valid) begin
                if (w_s_fire) begin
                    if (w_out_free) begin
                        // Straight through into the output register
                        r_m_data  <= s_data;
                        r_m_valid <= 1'b1;
                    end else begin
                        // Downstream stalled: park the beat, stop accepting
                        r_skid_data  <= s_data;
                        r_skid_valid <= 1'b1;
                        r_s_ready    <= 1'b0;
                    end
                end else if (m_ready) begin
                    r_m_valid <= 1'b0;
                end
            end else begin
                // Skid entry full: refill the output from it once drained
                r_s_ready <= 1'b0;
                if (m_ready) begin
                    r_m_data     <= r_skid_data;
                    r_skid_valid <= 1'b0;
                    r_s_ready    <= 1'b1;
                end
            end
        end
    end

    assign s_ready = r_s_ready;
    assign m_data  = r_m_data;
    assign m_valid = r_m_valid;

endmodule
`default_nettype wire

// File: rtl/eth_rx_fifo_reader.sv
`default_nettype none
// ============================================================================
//  Module      : eth_rx_fifo_reader
//  Description : Read-side consumer of the dual-clock Ethernet RX FIFO (FWFT).
//                Pops packed frame words, rebuilds AXI-Stream beats with
//                tkeep/tlast, tracks frame length, flags runt/oversize/errored
//                frames on tuser, truncates oversize frames and discards
//                their tail, and keeps saturating good/bad frame counters.
//  Revision    : 1.0  initial release
// ============================================================================
module eth_rx_fifo_reader
    import eth_rx_pkg::*;
#(
    parameter  int DATA_BYTES      = DEF_DATA_BYTES,
    parameter  int MIN_FRAME_BYTES = DEF_MIN_FRAME_BYTES,
    parameter  int MAX_FRAME_BYTES = DEF_MAX_FRAME_BYTES,
    parameter  int CNT_WIDTH       = 16,
    localparam int BCNT_W          = $clog2(DATA_BYTES),
    localparam int FIFO_W          = fifo_w(DATA_BYTES)
) (
    input  logic                    rd_clk,
    input  logic                    rd_rst,
    input  logic [FIFO_W-1:0]       fifo_rd_data,
    input  logic                    fifo_rd_empty,
    input  logic                    fifo_rst_busy,
    output logic                    fifo_rd_en,
    output logic [8*DATA_BYTES-1:0] m_axis_tdata,
    output logic [DATA_BYTES-1:0]   m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tuser,
    output logic [CNT_WIDTH-1:0]    frame_ok_cnt,
    output logic [CNT_WIDTH-1:0]    frame_bad_cnt,
    output logic                    in_frame
);

    localparam int                DATA_W  = 8 * DATA_BYTES;
    localparam int                LEN_W   = len_w(MAX_FRAME_BYTES, DATA_BYTES);
    localparam int                BEAT_W  = DATA_W + DATA_BYTES + 2;
    localparam logic [LEN_W-1:0]  MIN_LEN = LEN_W'(MIN_FRAME_BYTES);
    localparam logic [LEN_W-1:0]  MAX_LEN = LEN_W'(MAX_FRAME_BYTES);
    localparam logic [BCNT_W:0]   WB_ONE  = (BCNT_W + 1)'(1);
    localparam logic [BCNT_W:0]   WB_FULL = (BCNT_W + 1)'(DATA_BYTES);

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    state_t                 r_state;
    logic [LEN_W-1:0]       r_len;
    logic [CNT_WIDTH-1:0]   r_ok_cnt;
    logic [CNT_WIDTH-1:0]   r_bad_cnt;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic                   w_err;
    logic                   w_last;
    logic [BCNT_W-1:0]      w_nbytes_m1;
    logic [DATA_W-1:0]      w_data;
    logic [BCNT_W:0]        w_wb;
    logic [LEN_W-1:0]       w_len_base;
    logic [LEN_W-1:0]       w_len_next;
    logic [DATA_BYTES-1:0]  w_keep;
    logic                   w_too_long;
    logic                   w_bad;

    state_t                 w_state_next;
    logic [LEN_W-1:0]       w_len_d;

    logic                   w_skid_ready;
    logic                   w_pop;
    logic                   w_push;
    logic [DATA_BYTES-1:0]  w_beat_keep;
    logic                   w_beat_last;
    logic                   w_beat_user;
    logic                   w_ok_inc;
    logic                   w_bad_inc;
    logic [BEAT_W-1:0]      w_s_beat;
    logic [BEAT_W-1:0]      w_m_beat;

    // Unpack the FWFT head word into its fields
    assign {w_err, w_last, w_nbytes_m1, w_data} = fifo_rd_data;

    // Byte count of the head word, the length it produces, and its byte enables
    always_comb begin
        w_wb       = w_last ? ({1'b0, w_nbytes_m1} + WB_ONE) : WB_FULL;
        // A word popped in IDLE always starts a new frame from zero
        w_len_base = (r_state == IDLE) ? '0 : r_len;
        w_len_next = w_len_base + LEN_W'(w_wb);
        for (int i = 0; i < DATA_BYTES; i++) begin
            w_keep[i] = (i < int'(w_wb));
        end
        w_too_long = (w_len_next > MAX_LEN);
        w_bad      = w_err || (w_len_next < MIN_LEN) || w_too_long;
    end

    // State register and frame length accumulator
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_state <= IDLE;
            r_len   <= '0;
        end else begin
            r_state <= w_state_next;
            r_len   <= w_len_d;
        end
    end

    // Next-state and next-length decode; nothing moves without a pop, which
    // is what holds the FSM while the FIFO is empty or in reset
    always_comb begin
        w_state_next = r_state;
        w_len_d      = r_len;
        if (w_pop) begin
            case (r_state)
                IDLE, FRAME: begin
                    if (w_last) begin
                        w_state_next = IDLE;
                        w_len_d      = '0;
                    end else if (w_too_long) begin
                        w_state_next = DISCARD;
                        w_len_d      = '0;
                    end else begin
                        w_state_next = FRAME;
                        w_len_d      = w_len_next;
                    end
                end
                DISCARD: begin
                    if (w_last) begin
                        w_state_next = IDLE;
                        w_len_d      = '0;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                    w_len_d      = '0;
                end
            endcase
        end
    end

    // Pop strobe, beat formatting and counter strobes for the current state
    always_comb begin
        w_pop       = !fifo_rd_empty && !fifo_rst_busy &&
                      ((r_state == DISCARD) || w_skid_ready);
        w_push      = w_pop && (r_state != DISCARD);
        w_beat_keep = w_keep;
        w_beat_last = 1'b0;
        w_beat_user = 1'b0;
        w_ok_inc    = 1'b0;
        w_bad_inc   = 1'b0;
        if (w_push) begin
            if (w_last) begin
                // Natural end of frame: classify it
                w_beat_last = 1'b1;
                w_beat_user = w_bad;
                w_ok_inc    = !w_bad;
                w_bad_inc   = w_bad;
            end else if (w_too_long) begin
                // Oversize: close the frame early as bad, drop the tail
                w_beat_last = 1'b1;
                w_beat_user = 1'b1;
                w_beat_keep = '1;
                w_bad_inc   = 1'b1;
            end
        end
        in_frame = (r_state == FRAME) || (r_state == DISCARD);
    end

    // Saturating frame statistics, updated at pop time
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_ok_cnt  <= '0;
            r_bad_cnt <= '0;
        end else begin
            if (w_ok_inc && (r_ok_cnt != '1)) begin
                r_ok_cnt <= r_ok_cnt + CNT_WIDTH'(1);
            end
            if (w_bad_inc && (r_bad_cnt != '1)) begin
                r_bad_cnt <= r_bad_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign w_s_beat = {w_data, w_beat_keep, w_beat_last, w_beat_user};

    axis_skid_buffer #(
        .WIDTH   (BEAT_W)
    ) u_skid (
        .clk     (rd_clk),
        .rst     (rd_rst),
        .s_data  (w_s_beat),
        .s_valid (w_push),
        .s_ready (w_skid_ready),
        .m_data  (w_m_beat),
        .m_valid (m_axis_tvalid),
        .m_ready (m_axis_tready)
    );

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} = w_m_beat;
    assign fifo_rd_en    = w_pop;
    assign frame_ok_cnt  = r_ok_cnt;
    assign frame_bad_cnt = r_bad_cnt;

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_fifo_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eth_rx_fifo_reader
//  Description : Self-checking bench for eth_rx_fifo_reader. A queue stands in
//                for the FWFT FIFO; expected beats and counters come from a
//                frame-level model of the length/truncation rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_eth_rx_fifo_reader;
    import eth_rx_pkg::*;

    localparam int DB   = 4;
    localparam int MINB = 60;
    localparam int MAXB = 1522;
    localparam int CW   = 16;
    localparam int FW   = 8 * DB + 2 + 2;

    logic            rd_clk = 1'b0;
    logic            rd_rst = 1'b1;
    logic [FW-1:0]   fifo_rd_data = '0;
    logic            fifo_rd_empty = 1'b1;
    logic            fifo_rst_busy = 1'b0;
    logic            fifo_rd_en;
    logic [31:0]     tdata;
    logic [3:0]      tkeep;
    logic            tvalid;
    logic            tready = 1'b0;
    logic            tlast;
    logic            tuser;
    logic [CW-1:0]   ok_cnt;
    logic [CW-1:0]   bad_cnt;
    logic            in_frame;

    eth_rx_fifo_reader #(
        .DATA_BYTES      (DB),
        .MIN_FRAME_BYTES (MINB),
        .MAX_FRAME_BYTES (MAXB),
        .CNT_WIDTH       (CW)
    ) dut (
        .rd_clk        (rd_clk),
        .rd_rst        (rd_rst),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_empty (fifo_rd_empty),
        .fifo_rst_busy (fifo_rst_busy),
        .fifo_rd_en    (fifo_rd_en),
        .m_axis_tdata  (tdata),
        .m_axis_tkeep  (tkeep),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast),
        .m_axis_tuser  (tuser),
        .frame_ok_cnt  (ok_cnt),
        .frame_bad_cnt (bad_cnt),
        .in_frame      (in_frame)
    );

    always #5 rd_clk = ~rd_clk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic        user;
    } beat_t;

    logic [FW-1:0] fq[$];
    beat_t         eq[$];

    int npass = 0, nfail = 0, nchk = 0;
    int exp_ok = 0, exp_bad = 0;
    int cyc = 0;
    int gap_pct = 0, ready_pct = 100;
    bit hold_low = 1'b0, busy = 1'b0;
    int pops = 0, beats = 0, first_pop_cyc = 0, first_hs_cyc = 0, last_hs_cyc = 0;
    beat_t last_beat;
    beat_t prev_out;
    bit    prev_stall = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        nchk++;
        assert (obs === expv) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Load a frame of n bytes into the FIFO and derive its expected beats
    task automatic push_frame(input int n, input bit err);
        int            nw;
        int            trunc;
        int            cnt;
        logic [31:0]   wd;
        rx_fifo_word_t w;
        bit            bad;
        nw    = (n + DB - 1) / DB;
        trunc = MAXB / DB + 1;      // first word whose end passes MAXB
        bad   = err || (n < MINB) || (n > MAXB);
        for (int k = 0; k < nw; k++) begin
            cnt = (k == nw - 1) ? n - DB * k : DB;
            wd  = '0;
            for (int b = 0; b < cnt; b++) wd[8*b +: 8] = 8'($urandom);
            w.err       = (k == nw - 1) ? err : 1'b0;
            w.last      = (k == nw - 1);
            w.nbytes_m1 = 2'(cnt - 1);
            w.data      = wd;
            fq.push_back(w);
            if (nw > trunc) begin
                if (k < trunc) eq.push_back('{wd, 4'hF, (k == trunc - 1), (k == trunc - 1)});
            end else begin
                eq.push_back('{wd, (k == nw - 1) ? 4'((1 << cnt) - 1) : 4'hF,
                               (k == nw - 1), (k == nw - 1) && bad});
            end
        end
        if (nw > trunc || bad) exp_bad++;
        else exp_ok++;
    endtask

    // One clock: drive at the falling edge, sample 1 time unit later
    task automatic cycle();
        beat_t       b;
        logic [31:0] m;
        @(negedge rd_clk);
        fifo_rd_empty = (fq.size() == 0) || (gap_pct > 0 && $urandom_range(0, 99) < gap_pct);
        fifo_rd_data  = (fq.size() > 0) ? fq[0] : '0;
        tready        = !hold_low && ($urandom_range(0, 99) < ready_pct);
        fifo_rst_busy = busy;
        #1;
        if (prev_stall) begin
            check("hold_tvalid", tvalid, 1'b1);
            check("hold_tdata", tdata, prev_out.data);
            check("hold_tkeep", tkeep, prev_out.keep);
            check("hold_tlast", tlast, prev_out.last);
            check("hold_tuser", tuser, prev_out.user);
        end
        prev_stall = tvalid && !tready;
        prev_out   = '{tdata, tkeep, tlast, tuser};
        if (fifo_rd_empty || fifo_rst_busy) check("rd_en_blocked", fifo_rd_en, 1'b0);
        if (fifo_rd_en && fq.size() > 0) begin
            void'(fq.pop_front());
            if (pops == 0) first_pop_cyc = cyc;
            pops++;
        end
        if (tvalid && tready) begin
            check("beat_expected", (eq.size() > 0), 1'b1);
            if (eq.size() > 0) begin
                b = eq.pop_front();
                for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{b.keep[i]}};
                check("tdata", tdata & m, b.data & m);
                check("tkeep", tkeep, b.keep);
                check("tlast", tlast, b.last);
                check("tuser", tuser, b.user);
            end
            if (beats == 0) first_hs_cyc = cyc;
            last_hs_cyc = cyc;
            beats++;
            last_beat = '{tdata, tkeep, tlast, tuser};
        end
        cyc++;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((fq.size() > 0 || eq.size() > 0) && n < budget) begin
            cycle();
            n++;
        end
        check("drain_left", fq.size() + eq.size(), 0);
        repeat (4) cycle();
    endtask

    task automatic marks();
        pops  = 0;
        beats = 0;
    endtask

    initial begin
        int n;
        int r;
        int p;
        // ---- reset state ----
        repeat (3) @(negedge rd_clk);
        #1;
        check("rst_tvalid", tvalid, 1'b0);
        check("rst_tdata", tdata, 32'h0);
        check("rst_tkeep", tkeep, 4'h0);
        check("rst_tlast", tlast, 1'b0);
        check("rst_tuser", tuser, 1'b0);
        check("rst_ok", ok_cnt, 16'h0);
        check("rst_bad", bad_cnt, 16'h0);
        check("rst_in_frame", in_frame, 1'b0);
        check("rst_rd_en", fifo_rd_en, 1'b0);
        @(negedge rd_clk);
        rd_rst = 1'b0;
        repeat (2) cycle();

        // ---- 64-byte frame, full throughput ----
        marks();
        push_frame(64, 1'b0);
        drain(200);
        check("t1_beats", beats, 16);
        check("t1_b2b", last_hs_cyc - first_hs_cyc, 15);
        check("t1_latency", first_hs_cyc - first_pop_cyc, 1);
        check("t1_last_keep", last_beat.keep, 4'hF);
        check("t1_last_user", last_beat.user, 1'b0);
        check("t1_ok", ok_cnt, 16'd1);
        check("t1_in_frame", in_frame, 1'b0);

        // ---- 61-byte frame: single valid byte in last beat ----
        push_frame(61, 1'b0);
        drain(200);
        check("t2_keep", last_beat.keep, 4'h1);
        check("t2_user", last_beat.user, 1'b0);
        check("t2_ok", ok_cnt, 16'd2);

        // ---- 40-byte runt ----
        push_frame(40, 1'b0);
        drain(200);
        check("t3_user", last_beat.user, 1'b1);
        check("t3_bad", bad_cnt, 16'd1);
        check("t3_ok", ok_cnt, 16'd2);

        // ---- 1600-byte oversize frame, then a clean frame ----
        marks();
        push_frame(1600, 1'b0);
        drain(2000);
        check("t4_beats", beats, 381);
        check("t4_pops", pops, 400);
        check("t4_last", last_beat.last, 1'b1);
        check("t4_user", last_beat.user, 1'b1);
        check("t4_bad", bad_cnt, 16'd2);
        push_frame(64, 1'b0);
        drain(200);
        check("t4_ok", ok_cnt, 16'd3);

        // ---- random frames, random tready and FIFO gaps ----
        gap_pct   = 30;
        ready_pct = 60;
        for (int f = 0; f < 50; f++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      n = $urandom_range(1, 8);
            else if (r <= 7) n = $urandom_range(20, 200);
            else if (r == 8) n = $urandom_range(1500, 1530);
            else             n = $urandom_range(1590, 1600);
            push_frame(n, ($urandom_range(0, 5) == 0));
        end
        drain(40000);
        check("t5_ok", ok_cnt, 16'(exp_ok));
        check("t5_bad", bad_cnt, 16'(exp_bad));
        gap_pct   = 0;
        ready_pct = 100;

        // ---- tready held low: two beats buffered, then pops stop ----
        marks();
        hold_low = 1'b1;
        push_frame(64, 1'b0);
        repeat (10) cycle();
        check("t5_held_pops", pops, 2);
        check("t5_rd_en_off", fifo_rd_en, 1'b0);
        check("t5_tvalid", tvalid, 1'b1);
        hold_low = 1'b0;
        drain(200);
        check("t5_ok2", ok_cnt, 16'(exp_ok));

        // ---- err flag on the last word ----
        push_frame(64, 1'b1);
        drain(200);
        check("t6_err_user", last_beat.user, 1'b1);
        check("t6_err_bad", bad_cnt, 16'(exp_bad));

        // ---- fifo_rst_busy mid-frame ----
        marks();
        push_frame(64, 1'b0);
        repeat (5) cycle();
        busy = 1'b1;
        p = pops;
        repeat (5) begin
            cycle();
            check("t6_busy_rd_en", fifo_rd_en, 1'b0);
            check("t6_busy_in_frame", in_frame, 1'b1);
        end
        check("t6_busy_pops", pops, p);
        busy = 1'b0;
        drain(200);
        check("t6_busy_ok", ok_cnt, 16'(exp_ok));

        // ---- rd_rst mid-frame ----
        push_frame(64, 1'b0);
        repeat (6) cycle();
        @(negedge rd_clk);
        rd_rst = 1'b1;
        #1;
        check("t6_rst_tvalid", tvalid, 1'b0);
        check("t6_rst_ok", ok_cnt, 16'h0);
        check("t6_rst_bad", bad_cnt, 16'h0);
        check("t6_rst_in_frame", in_frame, 1'b0);
        check("t6_rst_rd_en", fifo_rd_en, 1'b0);
        fq.delete();
        eq.delete();
        exp_ok     = 0;
        exp_bad    = 0;
        prev_stall = 1'b0;
        @(negedge rd_clk);
        rd_rst = 1'b0;
        marks();
        push_frame(64, 1'b0);
        drain(200);
        check("t6_after_beats", beats, 16);
        check("t6_after_ok", ok_cnt, 16'd1);
        check("t6_after_bad", bad_cnt, 16'd0);
        check("t6_after_user", last_beat.user, 1'b0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached, passed=%0d of %0d", npass, nchk);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
